// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and the beat bundle
// shared by the sync generator and the colour stage.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP
                         + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP
                         + DEF_V_SYNC + DEF_V_BP;

  localparam int CW = 10;

  typedef logic [CW-1:0] coord_t;

  typedef struct packed {
    logic   h_sync;
    logic   v_sync;
    logic   active;
    coord_t x;
    coord_t y;
  } vga_beat_t;

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: one-clk strobe every DIV clks,
// issued on the clk after the count reaches DIV-1.
module clk_en_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic en
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      en  <= 1'b0;
    end else begin
      en  <= (cnt == LAST);
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters advanced on
// the pixel strobe, registered syncs and coordinates.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic       h_sync,
  output logic       v_sync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam coord_t H_VIS = coord_t'(H_ACTIVE);
  localparam coord_t H_SS  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SE  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t H_END = coord_t'(H_ACTIVE + H_FP
                                    + H_SYNC + H_BP - 1);
  localparam coord_t V_VIS = coord_t'(V_ACTIVE);
  localparam coord_t V_SS  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SE  = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t V_END = coord_t'(V_ACTIVE + V_FP
                                    + V_SYNC + V_BP - 1);

  coord_t    h;
  coord_t    v;
  vga_beat_t nxt;
  logic      h_last;
  logic      v_last;

  clk_en_div #(
    .DIV(2)
  ) u_div (
    .clk(clk),
    .rst(rst),
    .en (pix_en)
  );

  assign h_last = (h == H_END);
  assign v_last = (v == V_END);

  always_comb begin
    nxt        = '0;
    nxt.active = (h < H_VIS) && (v < V_VIS);
    nxt.h_sync = !((h >= H_SS) && (h < H_SE));
    nxt.v_sync = !((v >= V_SS) && (v < V_SE));
    nxt.x      = nxt.active ? h : '0;
    nxt.y      = nxt.active ? v : '0;
  end

  // Outputs sample the counters only on strobe cycles,
  // so they hold across the intermediate clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        h_sync      <= nxt.h_sync;
        v_sync      <= nxt.v_sync;
        active      <= nxt.active;
        x           <= nxt.x;
        y           <= nxt.y;
        frame_start <= (h == '0) && (v == '0);
        h           <= h_last ? '0 : h + coord_t'(1);
        if (h_last)
          v <= v_last ? '0 : v + coord_t'(1);
      end
    end
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1: 50 MHz system clock; reset rst, synchronous, active-high; clock clk.
REQ-010 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-011 SHALL have port pix_en, output, 1: one-clk strobe marking each pixel slot (clk/2).
REQ-012 SHALL have port h_sync, output, 1: horizontal sync, active-low.
REQ-013 SHALL have port v_sync, output, 1: vertical sync, active-low.
REQ-014 SHALL have port active, output, 1: high while (x,y) is in the visible area.
REQ-015 SHALL have port x, output, 10: current pixel column.
REQ-016 SHALL have port y, output, 10: current line.
REQ-017 SHALL have port frame_start, output, 1: one-clk pulse at pixel (0,0) of each frame.

Function
REQ-018 Internal divider SHALL toggle every clk; pix_en high on clk after each divider 0->1 transition, i.e. every second clk, first high 2 clks after rst deasserts.
REQ-019 Horizontal counter SHALL advance by one only on pix_en cycles, range 0..H_TOTAL-1 (H_TOTAL = sum of H params, 800), wrapping to 0.
REQ-020 Vertical counter SHALL advance by one only on the pix_en cycle where horizontal counter wraps, range 0..V_TOTAL-1 (525), wrapping to 0; simultaneous h and v wrap SHALL give (0,0).
REQ-021 active SHALL be high iff h < H_ACTIVE and v < V_ACTIVE.
REQ-022 h_sync SHALL be low iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-023 v_sync SHALL be low iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-024 x,y SHALL equal h,v when active, and 0 when not active.
REQ-025 All outputs SHALL be registered; h_sync, v_sync, active, x, y SHALL reflect the counter value with exactly 1 clk latency and hold stable between pix_en strobes.
REQ-026 frame_start SHALL be high for exactly one clk, in the clk where x=0,y=0,active=1 first appear; never otherwise.
REQ-027 Counter compare widths SHALL be 10 bits; no arithmetic overflow permitted for default parameters.

Reset
REQ-028 While rst high: counters=0, divider=0, pix_en=0, h_sync=1, v_sync=1, active=0, x=0, y=0, frame_start=0.
REQ-029 Reset asserted mid-frame SHALL take effect at next clk edge; after release, timing SHALL restart at (0,0) with frame_start issued for the first pixel.

Structure
REQ-030 Default timing constants and H_TOTAL/V_TOTAL SHALL live in shared package vga_timing_pkg, also used by the downstream colour stage.
REQ-031 Pixel strobe divider SHALL be sub-module clk_en_div (parameter DIV, default 2).

Verification
REQ-032 Release rst -> pix_en first high 2 clks later, frame_start high same clk as x=0,y=0,active=1.
REQ-033 Run one line -> h_sync low for 192 clks starting at pixel 656, active high for 1280 clks, line period 1600 clks.
REQ-034 Run full frame -> v_sync low for 2 lines (3200 clks) at lines 490-491, frame period 840000 clks, second frame_start exactly 840000 clks after first.
REQ-035 Observe pixel (639,479)->(640,479) -> active falls, x and y go to 0; at (799,524) next pixel is (0,0).
REQ-036 Assert rst for 1 clk at line 300, pixel 400 -> all outputs at reset values next clk; frame restarts from (0,0).
REQ-037 Between pix_en strobes -> x, y, active, syncs unchanged on the intermediate clk.
